symbol_timing_ctrl: RTL
=======================

SYMBOL_TIMING_CTRL -- requirements
Module: symbol_timing_ctrl

Interface
REQ-001 Parameter: MAX_SYMBOLS, 6, max symbols per character; range 1..7.
REQ-002 Port: clk  in  1  sole clock; all logic rising-edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: key_i  in  1  synchronized, debounced key level; 1 = pressed.
REQ-005 Ports: dash_set_o, illegal_set_o, char_set_o, word_set_o  out  1 each  set/hold input of the four timer instances; 1 = hold cleared, 0 = count.
REQ-006 Ports: dash_expired_i, illegal_expired_i, char_expired_i, word_expired_i  in  1 each  level expired flag of each timer; held high until its set is asserted.
REQ-007 Port: sym_valid_o  out  1  one-cycle strobe, legal symbol completed.
REQ-008 Port: sym_dash_o  out  1  symbol type, qualified by sym_valid_o; 0 dot, 1 dash.
REQ-009 Port: sym_err_o  out  1  one-cycle strobe, illegal symbol or symbol-count overflow.
REQ-010 Port: char_done_o, word_done_o  out  1 each  one-cycle end-of-character / end-of-word strobes.
REQ-011 Port: sym_count_o  out  3  legal symbols accepted in current character.

Function
REQ-012 States: IDLE, MARK, MARK_ERR, SPACE, GAP; one-hot or binary encoding is free.
REQ-013 Set outputs are Moore decodes of the state register: dash/illegal set = 0 only in MARK; char set = 0 only in SPACE; word set = 0 only in SPACE and GAP; all others 1.
REQ-014 IDLE: key_i=1 with arm flag set -> MARK, sym_count_o cleared.
REQ-015 Arm flag is cleared by reset and set on the first cycle key_i=0; a press held through reset is ignored until released.
REQ-016 MARK: illegal_expired_i=1 -> sym_err_o pulse, MARK_ERR; illegal expiry wins over a same-cycle release.
REQ-017 MARK: key_i=0 (no illegal expiry) -> sym_valid_o pulse with sym_dash_o = dash_expired_i sampled that cycle, sym_count_o+1, SPACE.
REQ-018 MARK release when sym_count_o = MAX_SYMBOLS: sym_err_o pulse instead of sym_valid_o, sym_count_o cleared, IDLE.
REQ-019 MARK_ERR: wait key_i=0 -> IDLE, sym_count_o cleared, no char_done_o.
REQ-020 SPACE: key_i=1 before char expiry -> MARK, same character continues.
REQ-021 SPACE: char_expired_i=1 -> char_done_o pulse, GAP; with same-cycle key_i=1, char_done_o pulses and next state is MARK with sym_count_o cleared.
REQ-022 GAP: word_expired_i=1 -> word_done_o pulse, IDLE; key_i=1 -> MARK, sym_count_o cleared; if both in one cycle, word_done_o pulses and next state is MARK.
REQ-023 All strobes are registered, asserted exactly one cycle after the causing input sample, never asserted together except char_done_o with nothing else.
REQ-024 sym_count_o saturates at MAX_SYMBOLS; never wraps.

Reset
REQ-025 On reset: state IDLE, all four set outputs 1, all strobes 0, sym_dash_o 0, sym_count_o 0, arm flag 0.
REQ-026 Reset asserted mid-operation takes effect at the next clk edge; no strobe is emitted for the aborted symbol or character.

Configuration
REQ-027 Macro MORSE_WORD_DETECT_EN: defined -> GAP state, word timer and word_done_o behave as above.
REQ-028 Without MORSE_WORD_DETECT_EN: word_set_o tied 1, word_done_o tied 0, GAP removed; SPACE char expiry -> char_done_o and IDLE directly.

Verification
REQ-029 Bench instantiates four real timers with DASH/ILLEGAL_SYMBOL/CHAR/WORD_TICK_COUNT_C from morse_decoder_pkg.
REQ-030 Press for DASH_TICK_COUNT_C/2 cycles, release -> one sym_valid_o with sym_dash_o=0, sym_count_o=1, char_done_o after CHAR_TICK_COUNT_C+2 cycles, word_done_o after WORD_TICK_COUNT_C+2 cycles of silence.
REQ-031 Press 2*DASH_TICK_COUNT_C (< illegal), release, press again within CHAR_TICK_COUNT_C/2 -> two symbols (dash then per press), single char_done_o, sym_count_o=2.
REQ-032 Hold key ILLEGAL_SYMBOL_TICK_COUNT_C+10 cycles -> one sym_err_o, no sym_valid_o, no char_done_o, IDLE after release.
REQ-033 Seven dots with MAX_SYMBOLS=6 -> six sym_valid_o, then sym_err_o, sym_count_o=0, no char_done_o.
REQ-034 Key held high through reset deassert -> no MARK until key seen 0; reset pulsed mid-SPACE -> all set outputs 1 next cycle, no char_done_o.

Source files
------------

// File: rtl/symbol_timing_ctrl.sv
// Morse key symbol timing controller: sequences four external timers to classify key presses
// into dots/dashes, detect illegal holds and emit end-of-character/word strobes.
// Optional word detection (GAP state, word timer, word_done_o) is enabled by defining MORSE_WORD_DETECT_EN.
module symbol_timing_ctrl #(
  parameter int MAX_SYMBOLS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_i,
  output logic       dash_set_o,
  output logic       illegal_set_o,
  output logic       char_set_o,
  output logic       word_set_o,
  input  logic       dash_expired_i,
  input  logic       illegal_expired_i,
  input  logic       char_expired_i,
  input  logic       word_expired_i,
  output logic       sym_valid_o,
  output logic       sym_dash_o,
  output logic       sym_err_o,
  output logic       char_done_o,
  output logic       word_done_o,
  output logic [2:0] sym_count_o
);

  localparam logic [2:0] MAX_CNT_C = 3'(MAX_SYMBOLS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MARK     = 3'd1,
    S_MARK_ERR = 3'd2,
`ifdef MORSE_WORD_DETECT_EN
    S_SPACE    = 3'd3,
    S_GAP      = 3'd4
`else
    S_SPACE    = 3'd3
`endif
  } state_t;

  state_t     r_state;
  logic       r_arm;
  logic [2:0] r_count;
  logic       r_sym_valid;
  logic       r_sym_dash;
  logic       r_sym_err;
  logic       r_char_done;
  logic       w_mark_set;
  logic       w_char_set;

  // Moore decode of the timer hold inputs from the state register
  always_comb begin
    w_mark_set = 1'b1;
    w_char_set = 1'b1;
    case (r_state)
      S_MARK:  w_mark_set = 1'b0;
      S_SPACE: w_char_set = 1'b0;
      default: begin
        w_mark_set = 1'b1;
        w_char_set = 1'b1;
      end
    endcase
  end

`ifdef MORSE_WORD_DETECT_EN
  logic r_word_done;
  logic w_word_set;

  // Word timer runs through the inter-symbol space and the inter-character gap
  always_comb begin
    w_word_set = 1'b1;
    case (r_state)
      S_SPACE: w_word_set = 1'b0;
      S_GAP:   w_word_set = 1'b0;
      default: w_word_set = 1'b1;
    endcase
  end

  assign word_set_o  = w_word_set;
  assign word_done_o = r_word_done;
`else
  logic w_unused_word_expired;
  assign w_unused_word_expired = word_expired_i;
  assign word_set_o  = 1'b1;
  assign word_done_o = 1'b0;
`endif

  // Main symbol/character FSM with registered strobes, counter and arm flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_arm       <= 1'b0;
      r_count     <= 3'd0;
      r_sym_valid <= 1'b0;
      r_sym_dash  <= 1'b0;
      r_sym_err   <= 1'b0;
      r_char_done <= 1'b0;
`ifdef MORSE_WORD_DETECT_EN
      r_word_done <= 1'b0;
`endif
    end else begin
      r_sym_valid <= 1'b0;
      r_sym_err   <= 1'b0;
      r_char_done <= 1'b0;
`ifdef MORSE_WORD_DETECT_EN
      r_word_done <= 1'b0;
`endif
      // A press held through reset stays ignored until the key is seen released
      r_arm <= r_arm | ~key_i;
      case (r_state)
        S_IDLE: begin
          if (key_i && r_arm) begin
            r_state <= S_MARK;
            r_count <= 3'd0;
          end
        end
        S_MARK: begin
          if (illegal_expired_i) begin
            r_sym_err <= 1'b1;
            r_state   <= S_MARK_ERR;
          end else if (!key_i) begin
            if (r_count >= MAX_CNT_C) begin
              r_sym_err <= 1'b1;
              r_count   <= 3'd0;
              r_state   <= S_IDLE;
            end else begin
              r_sym_valid <= 1'b1;
              r_sym_dash  <= dash_expired_i;
              r_count     <= r_count + 3'd1;
              r_state     <= S_SPACE;
            end
          end
        end
        S_MARK_ERR: begin
          if (!key_i) begin
            r_count <= 3'd0;
            r_state <= S_IDLE;
          end
        end
        S_SPACE: begin
          if (char_expired_i) begin
            r_char_done <= 1'b1;
            if (key_i) begin
              r_count <= 3'd0;
              r_state <= S_MARK;
            end else begin
`ifdef MORSE_WORD_DETECT_EN
              r_state <= S_GAP;
`else
              r_state <= S_IDLE;
`endif
            end
          end else if (key_i) begin
            r_state <= S_MARK;
          end
        end
`ifdef MORSE_WORD_DETECT_EN
        S_GAP: begin
          if (word_expired_i) begin
            r_word_done <= 1'b1;
          end
          if (key_i) begin
            r_count <= 3'd0;
            r_state <= S_MARK;
          end else if (word_expired_i) begin
            r_state <= S_IDLE;
          end
        end
`endif
        default: begin
          r_count <= 3'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dash_set_o    = w_mark_set;
  assign illegal_set_o = w_mark_set;
  assign char_set_o    = w_char_set;
  assign sym_valid_o   = r_sym_valid;
  assign sym_dash_o    = r_sym_dash;
  assign sym_err_o     = r_sym_err;
  assign char_done_o   = r_char_done;
  assign sym_count_o   = r_count;

endmodule
